sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core, between its inst/data SRAM-style ports and a single AXI3 master port.
- Converts each core request into one single-beat AXI transaction. One transaction is outstanding at a time, and data requests have priority over instruction requests.
- Drives per-side stall signals so the core's CTRL holds the pipeline until the response returns.
- Performs fixed kseg0/kseg1 virtual-to-physical translation.

Parameters:
INST_ID, 4'd0, AXI ID used for instruction reads
DATA_ID, 4'd1, AXI ID used for data reads/writes
ADDR_MAP_EN, 1, 1 = clear addr[31:29] when it equals 3'b100 or 3'b101; 0 = pass-through

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when rst==0)
inst_sram_en  in  1  instruction fetch request
inst_sram_addr  in  32  fetch virtual address
inst_sram_rdata  out  32  fetched word, registered
inst_stall  out  1  instruction side not yet complete
data_sram_en  in  1  data access request
data_sram_wen  in  4  byte write enables; 0 = read
data_sram_addr  in  32  data virtual address
data_sram_wdata  in  32  store data
data_sram_rdata  out  32  load word, registered
data_stall  out  1  data side not yet complete
arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address
arready  in  1
rid/rdata/rvalid  in  4/32/1  AXI read data
rready  out  1
awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address
awready  in  1
wdata/wstrb/wvalid  out  32/4/1  AXI write data; wlast tied to 1 at top level
wready  in  1
bvalid  in  1
bready  out  1

Fixed AXI fields (len=0, burst=INCR, lock/cache/prot=0) are tied off at top level and are not ports.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All valid/ready outputs go to 0.
  - inst_done and data_done go to 0.
  - Both rdata registers go to 32'h0.
  - Any in-flight transaction is abandoned; reset is SoC-wide.
- Stall outputs (combinational):
  - inst_stall = inst_sram_en & ~inst_done
  - data_stall = data_sram_en & ~data_done
- Core contract: the core holds en/addr/wen/wdata stable while either stall is high.
- advance = ~inst_stall & ~data_stall. On advance, both done flags clear next cycle, so a completed side is never re-issued while the other side is still pending.
- State machine: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
  - IDLE, data side: if data_stall, latch the translated address.
    - wen==0: go to RD_ADDR with id=DATA_ID.
    - wen!=0: go to WR_REQ.
  - IDLE, inst side: else if inst_stall, go to RD_ADDR with id=INST_ID.
  - Launch happens the cycle after the request is seen; valid is registered.
  - RD_ADDR: arvalid=1, arsize=3'b010. On arready, go to RD_DATA.
  - RD_DATA: rready=1. On rvalid, write rdata into the rdata register selected by the latched ID, set that side's done flag, and go to IDLE.
  - WR_REQ: awvalid and wvalid are both asserted together; each drops independently on its own ready. awsize=3'b010, wstrb=wen. When both handshakes have completed (same or different cycles), go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, set data_done and go to IDLE. bresp is ignored.
- Minimum latency, with ready signals held high: read 3 cycles from request to stall low; write 3 cycles.
- Both sides requesting in the same cycle: data is served first, then instruction. Both done flags are held until advance.
- rdata registers hold their value until the next completion on that side.
- rid is not checked against the latched ID; only one transaction is ever outstanding.

Test Plan:
- Reset: drive rst=0 for 3 cycles with both en=1 -> all valids 0, both rdata 0, both stalls 1, and arvalid stays low while rst==0.
- Instruction fetch: addr 32'hBFC0_0000, slave returns 32'h2408_0001 with 2-cycle arready delay -> araddr 32'h1FC0_0000, arid 0, inst_rdata 32'h2408_0001, inst_stall low for exactly the advance cycle.
- Store: data wen 4'b0011, addr 32'h8000_0010, wdata 32'hDEAD_BEEF, wready asserted 3 cycles after awready -> awaddr 32'h0000_0010, wstrb 4'b0011, bready only after both handshakes, data_stall drops after bvalid.
- Simultaneous load + fetch: load addr 32'hA000_0100 and fetch issued together -> AR sequence is data (id 1) then inst (id 0); no third AR; neither stall low until both are done.
- Reset mid-read: assert rst in RD_DATA before rvalid -> IDLE next cycle, rready 0, done flags 0, and a fresh AR is issued after rst releases.
- ADDR_MAP_EN=0: addr 32'h9FC0_0004 -> araddr 32'h9FC0_0004 unchanged.

Source files
------------

// File: rtl/sram_axi_bridge.sv
`default_nettype none
//============================================================================
// Module : sram_axi_bridge
// Brief  : Core inst/data SRAM-style ports to one single-beat AXI3 master,
//          one transaction in flight, data served before instruction.
// Rev    : 1.0  initial release
//============================================================================
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID     = 4'd0,
    parameter logic [3:0] DATA_ID     = 4'd1,
    parameter bit         ADDR_MAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_stall,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_stall,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_ADDR = 3'd1;
    localparam logic [2:0] c_ST_RD_DATA = 3'd2;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd3;
    localparam logic [2:0] c_ST_WR_RESP = 3'd4;
    localparam logic [2:0] c_SIZE_WORD  = 3'b010;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_inst_done;
    logic        r_data_done;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_arvalid;
    logic        r_awvalid;
    logic        r_wvalid;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        w_inst_stall;
    logic        w_data_stall;
    logic        w_advance;
    logic        w_aw_ok;
    logic        w_w_ok;
    logic        w_rd_fire;
    logic        w_launch;
    logic [3:0]  w_unused_rid;

    // kseg0/kseg1 both alias the low 512 MB of physical space
    function automatic logic [31:0] f_translate(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        if (ADDR_MAP_EN && (va[31:29] == 3'b100 || va[31:29] == 3'b101)) begin
            pa[31:29] = 3'b000;
        end
        return pa;
    endfunction

    assign w_inst_stall = inst_sram_en & ~r_inst_done;
    assign w_data_stall = data_sram_en & ~r_data_done;
    assign w_advance    = ~w_inst_stall & ~w_data_stall;
    assign w_aw_ok      = ~r_awvalid | awready;
    assign w_w_ok       = ~r_wvalid | wready;
    assign w_rd_fire    = (r_state == c_ST_RD_DATA) && rvalid;
    assign w_launch     = (r_state == c_ST_IDLE) && (w_data_stall || w_inst_stall);
    assign w_unused_rid = rid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_data_stall) begin
                    w_state_next = (data_sram_wen == 4'b0000) ? c_ST_RD_ADDR : c_ST_WR_REQ;
                end else if (w_inst_stall) begin
                    w_state_next = c_ST_RD_ADDR;
                end
            end
            c_ST_RD_ADDR: if (arready) w_state_next = c_ST_RD_DATA;
            c_ST_RD_DATA: if (rvalid) w_state_next = c_ST_IDLE;
            c_ST_WR_REQ:  if (w_aw_ok && w_w_ok) w_state_next = c_ST_WR_RESP;
            c_ST_WR_RESP: if (bvalid) w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            r_arvalid <= (w_state_next == c_ST_RD_ADDR);
            // AW and W are launched together but retire independently
            if (r_state == c_ST_IDLE && w_state_next == c_ST_WR_REQ) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else begin
                if (awready) r_awvalid <= 1'b0;
                if (wready)  r_wvalid  <= 1'b0;
            end
            if (w_advance) begin
                r_inst_done <= 1'b0;
                r_data_done <= 1'b0;
            end else begin
                if (w_rd_fire && r_id == DATA_ID) r_data_done <= 1'b1;
                if (w_rd_fire && r_id != DATA_ID) r_inst_done <= 1'b1;
                if (r_state == c_ST_WR_RESP && bvalid) r_data_done <= 1'b1;
            end
            if (w_rd_fire && r_id == DATA_ID) r_data_rdata <= rdata;
            if (w_rd_fire && r_id != DATA_ID) r_inst_rdata <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_launch) begin
            if (w_data_stall) begin
                r_id    <= DATA_ID;
                r_addr  <= f_translate(data_sram_addr);
                r_wstrb <= data_sram_wen;
                r_wdata <= data_sram_wdata;
            end else begin
                r_id    <= INST_ID;
                r_addr  <= f_translate(inst_sram_addr);
            end
        end
    end

    assign inst_sram_rdata = r_inst_rdata;
    assign data_sram_rdata = r_data_rdata;
    assign inst_stall      = w_inst_stall;
    assign data_stall      = w_data_stall;
    assign arid            = r_id;
    assign araddr          = r_addr;
    assign arsize          = c_SIZE_WORD;
    assign arvalid         = r_arvalid;
    assign rready          = (r_state == c_ST_RD_DATA);
    assign awid            = r_id;
    assign awaddr          = r_addr;
    assign awsize          = c_SIZE_WORD;
    assign awvalid         = r_awvalid;
    assign wdata           = r_wdata;
    assign wstrb           = r_wstrb;
    assign wvalid          = r_wvalid;
    assign bready          = (r_state == c_ST_WR_RESP);

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
//============================================================================
// Module : tb_sram_axi_bridge
// Brief  : Randomized bench for sram_axi_bridge against a transaction-queue
//          model of the core requests and a reactive AXI slave.
// Rev    : 1.0  initial release
//============================================================================
module tb_sram_axi_bridge;

    localparam logic [3:0] c_INST_ID = 4'd0;
    localparam logic [3:0] c_DATA_ID = 4'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_sram_en, data_sram_en;
    logic [31:0] inst_sram_addr, data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wen;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        inst_stall, data_stall;
    logic [3:0]  arid, awid, rid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;
    // pass-through instance outputs
    logic [31:0] n_inst_rdata, n_data_rdata, n_araddr, n_awaddr, n_wdata;
    logic        n_inst_stall, n_data_stall, n_arvalid, n_rready, n_awvalid, n_wvalid, n_bready;
    logic [3:0]  n_arid, n_awid, n_wstrb;
    logic [2:0]  n_arsize, n_awsize;

    sram_axi_bridge #(.INST_ID(c_INST_ID), .DATA_ID(c_DATA_ID), .ADDR_MAP_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata), .inst_stall(inst_stall),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .data_stall(data_stall),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    sram_axi_bridge #(.INST_ID(c_INST_ID), .DATA_ID(c_DATA_ID), .ADDR_MAP_EN(1'b0)) u_nomap (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(n_inst_rdata), .inst_stall(n_inst_stall),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(n_data_rdata), .data_stall(n_data_stall),
        .arid(n_arid), .araddr(n_araddr), .arsize(n_arsize), .arvalid(n_arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(n_rready),
        .awid(n_awid), .awaddr(n_awaddr), .awsize(n_awsize), .awvalid(n_awvalid), .awready(awready),
        .wdata(n_wdata), .wstrb(n_wstrb), .wvalid(n_wvalid), .wready(wready),
        .bvalid(bvalid), .bready(n_bready)
    );

    typedef struct packed {
        logic        is_wr;
        logic [3:0]  id;
        logic [31:0] raw;
        logic [31:0] pa;
        logic [3:0]  strb;
        logic [31:0] wd;
    } txn_t;

    txn_t        q[$];
    txn_t        cur_wr;
    logic [31:0] force_rd[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    bit          fast, inst_cmpl, data_cmpl;
    logic [31:0] exp_inst_rd, exp_data_rd;
    bit          rd_pend, rd_hold, aw_got, w_got, b_pend, wr_active;
    bit          hs_ar, hs_r, hs_aw, hs_w, hs_b;
    int          rd_dly, b_dly, ar_wait, w_wait;
    logic [31:0] rd_val;
    logic [3:0]  rd_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // physical address from the fixed segment map, as plain arithmetic
    function automatic logic [31:0] v2p(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    task automatic build_queue();
        q.delete();
        if (data_sram_en)
            q.push_back({(data_sram_wen != 4'b0), c_DATA_ID, data_sram_addr,
                         v2p(data_sram_addr), data_sram_wen, data_sram_wdata});
        if (inst_sram_en)
            q.push_back({1'b0, c_INST_ID, inst_sram_addr, v2p(inst_sram_addr), 4'b0, 32'h0});
    endtask

    task automatic slave_reset();
        rd_pend = 0; rd_hold = 0; aw_got = 0; w_got = 0; b_pend = 0; wr_active = 0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        rd_dly = 0; b_dly = 0; ar_wait = 0; w_wait = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = 32'h0; rid = 4'h0;
    endtask

    task automatic step();
        txn_t t;
        @(negedge clk);
        cyc++;
        // consequences of handshakes taken at the previous rising edge
        if (hs_ar) begin
            rd_pend = 1;
            rd_dly  = fast ? 0 : int'($urandom_range(0, 3));
            rd_val  = (force_rd.size() > 0) ? force_rd.pop_front() : $urandom;
        end
        if (hs_r) begin
            rd_pend = 0;
            if (rd_id == c_DATA_ID) begin exp_data_rd = rd_val; data_cmpl = 1; end
            else begin exp_inst_rd = rd_val; inst_cmpl = 1; end
        end
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got  = 1;
        if (hs_b) begin
            b_pend = 0; aw_got = 0; w_got = 0; wr_active = 0; data_cmpl = 1;
        end else if (wr_active && aw_got && w_got && !b_pend) begin
            b_pend = 1;
            b_dly  = fast ? 0 : int'($urandom_range(0, 3));
        end

        check("inst_stall", 32'(inst_stall), 32'(inst_sram_en & ~inst_cmpl));
        check("data_stall", 32'(data_stall), 32'(data_sram_en & ~data_cmpl));
        check("inst_rdata", inst_sram_rdata, exp_inst_rd);
        check("data_rdata", data_sram_rdata, exp_data_rd);
        check("bready_early", 32'(bready & ~(aw_got & w_got)), 32'h0);
        check("spurious_ar", 32'(arvalid && q.size() == 0), 32'h0);
        check("spurious_aw", 32'(awvalid && q.size() == 0 && !wr_active), 32'h0);

        if (ar_wait > 0 && arvalid) begin arready = 0; ar_wait--; end
        else arready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        awready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        if (w_wait > 0 && wvalid) begin wready = 0; w_wait--; end
        else wready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_pend && !rd_hold && rd_dly == 0) begin
            rvalid = 1; rdata = rd_val; rid = rd_id;
        end else begin
            rvalid = 0; rdata = $urandom;
            if (rd_pend && rd_dly > 0) rd_dly--;
        end
        if (b_pend && b_dly == 0) bvalid = 1;
        else begin
            bvalid = 0;
            if (b_pend && b_dly > 0) b_dly--;
        end

        hs_ar = arvalid && arready;
        if (hs_ar) begin
            check("ar_expected", 32'(q.size() > 0 && !q[0].is_wr), 32'h1);
            if (q.size() > 0) begin
                t = q.pop_front();
                rd_id = t.id;
                check("arid", 32'(arid), 32'(t.id));
                check("araddr", araddr, t.pa);
                check("arsize", 32'(arsize), 32'h2);
                check("araddr_nomap", n_araddr, t.raw);
            end
        end
        hs_r  = rvalid && rready;
        hs_aw = awvalid && awready;
        hs_w  = wvalid && wready;
        if ((hs_aw || hs_w) && !wr_active) begin
            check("wr_expected", 32'(q.size() > 0 && q[0].is_wr), 32'h1);
            if (q.size() > 0) begin cur_wr = q.pop_front(); wr_active = 1; end
        end
        if (hs_aw) begin
            check("awid", 32'(awid), 32'(cur_wr.id));
            check("awaddr", awaddr, cur_wr.pa);
            check("awsize", 32'(awsize), 32'h2);
            check("awaddr_nomap", n_awaddr, cur_wr.raw);
        end
        if (hs_w) begin
            check("wdata", wdata, cur_wr.wd);
            check("wstrb", 32'(wstrb), 32'(cur_wr.strb));
        end
        hs_b = bvalid && bready;
    endtask

    task automatic apply_req(input bit ie, input logic [31:0] ia, input bit de,
                             input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd);
        inst_sram_en = ie; inst_sram_addr = ia;
        data_sram_en = de; data_sram_wen = wen; data_sram_addr = da; data_sram_wdata = wd;
        build_queue();
        req_cyc = cyc;
    endtask

    // hold=1 leaves the request asserted through the advance cycle
    task automatic finish_req(input int lat_exp, input bit hold);
        int n;
        bit done;
        n = 0;
        do begin
            step();
            n++;
            done = (!inst_sram_en || inst_cmpl) && (!data_sram_en || data_cmpl);
        end while (!done && n < 200);
        check("req_complete", 32'(done), 32'h1);
        if (lat_exp > 0) check("latency", 32'(cyc - req_cyc), 32'(lat_exp));
        check("queue_drained", 32'(q.size()), 32'h0);
        if (hold) begin
            inst_cmpl = 0; data_cmpl = 0;
            build_queue();
            req_cyc = cyc + 1;
        end else begin
            inst_sram_en = 0; data_sram_en = 0;
            step();
            inst_cmpl = 0; data_cmpl = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ie, de;
        logic [3:0] wen;
        rst = 0;
        inst_sram_en = 1; inst_sram_addr = 32'hBFC0_0000;
        data_sram_en = 1; data_sram_wen = 4'h0; data_sram_addr = 32'h8000_0000;
        data_sram_wdata = 32'h0;
        fast = 0; inst_cmpl = 0; data_cmpl = 0;
        exp_inst_rd = 32'h0; exp_data_rd = 32'h0;
        slave_reset();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_arvalid", 32'(arvalid), 32'h0);
            check("rst_awvalid", 32'(awvalid), 32'h0);
            check("rst_wvalid", 32'(wvalid), 32'h0);
            check("rst_rready", 32'(rready), 32'h0);
            check("rst_bready", 32'(bready), 32'h0);
            check("rst_inst_rdata", inst_sram_rdata, 32'h0);
            check("rst_data_rdata", data_sram_rdata, 32'h0);
            check("rst_inst_stall", 32'(inst_stall), 32'h1);
            check("rst_data_stall", 32'(data_stall), 32'h1);
        end
        rst = 1; inst_sram_en = 0; data_sram_en = 0;

        fast = 1;
        ar_wait = 2;
        force_rd.push_back(32'h2408_0001);
        apply_req(1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0);
        finish_req(5, 1);
        finish_req(3, 0);

        apply_req(0, 32'h0, 1, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF);
        w_wait = 3;
        finish_req(6, 0);

        apply_req(1, 32'hBFC0_0010, 1, 4'h0, 32'hA000_0100, 32'h0);
        finish_req(6, 0);

        apply_req(1, 32'h9FC0_0004, 0, 4'h0, 32'h0, 32'h0);
        finish_req(3, 0);

        // reset while the read response is outstanding
        apply_req(0, 32'h0, 1, 4'h0, 32'hA000_0200, 32'h0);
        rd_hold = 1;
        for (int i = 0; i < 20 && !rready; i++) step();
        check("reached_rd_data", 32'(rready), 32'h1);
        rst = 0; rvalid = 0;
        @(negedge clk);
        cyc++;
        check("mid_rst_rready", 32'(rready), 32'h0);
        check("mid_rst_arvalid", 32'(arvalid), 32'h0);
        check("mid_rst_data_stall", 32'(data_stall), 32'h1);
        check("mid_rst_data_rdata", data_sram_rdata, 32'h0);
        check("mid_rst_inst_rdata", inst_sram_rdata, 32'h0);
        exp_inst_rd = 32'h0; exp_data_rd = 32'h0;
        slave_reset();
        rst = 1;
        build_queue();
        req_cyc = cyc;
        finish_req(3, 0);

        fast = 0;
        for (int i = 0; i < 40; i++) begin
            ie  = 1'($urandom_range(0, 1));
            de  = 1'($urandom_range(0, 1));
            if (!ie && !de) ie = 1;
            wen = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            apply_req(ie, $urandom & 32'hFFFF_FFFC, de, wen, $urandom & 32'hFFFF_FFFC, $urandom);
            finish_req(0, 0);
            if ($urandom_range(0, 2) == 0) step();
        end

        fast = 1;
        for (int i = 0; i < 8; i++) begin
            ie  = 1'($urandom_range(0, 1));
            de  = 1'($urandom_range(0, 1));
            if (!ie && !de) de = 1;
            wen = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
            apply_req(ie, $urandom & 32'hFFFF_FFFC, de, wen, $urandom & 32'hFFFF_FFFC, $urandom);
            finish_req((ie && de) ? 6 : 3, 0);
        end

        for (int i = 0; i < 4; i++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
